mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 158 +++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: drives the data-cache handshake for loads and stores,
// maintains the LL/SC link register and feeds the MEM/WB latch.
module mem_stage (
  input  logic        CLK,
  input  logic        nRST,
  // EX/MEM latch
  input  logic        exmem_valid,
  input  logic [31:0] aluOutport_in,
  input  logic [31:0] storedata_in,
  input  logic [31:0] pcplus4_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        LL_in,
  input  logic        SC_in,
  input  logic [5:0]  ctrl_in,
  input  logic        flush_in,
  // data cache
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  // MEM/WB latch
  output logic [31:0] aluOutport_out,
  output logic [31:0] dmemload_out,
  output logic [31:0] pcplus4_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  rd_out,
  output logic [5:0]  ctrl_out,
  output logic        memwb_writeEN,
  output logic        memwb_flush,
  output logic        mem_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic [31:0] ldata_q, ldata_d;
  logic        pend_flush_q, pend_flush_d;

  logic        link_match;
  logic        sc_fail;
  logic        memop;

  // The upstream latch holds the instruction while stalled, so these follow it directly
  assign pcplus4_out = pcplus4_in;
  assign rt_out      = rt_in;
  assign rd_out      = rd_in;
  assign ctrl_out    = ctrl_in;
  assign dmemaddr    = aluOutport_in;
  assign dmemstore   = storedata_in;

  // A failing SC never touches the cache, so it is not a memory operation
  assign link_match = link_valid_q && (link_addr_q == aluOutport_in);
  assign sc_fail    = SC_in && !link_match;
  assign memop      = exmem_valid && (dREN_in || dWEN_in) && !sc_fail;

  // Next-state, link bookkeeping and stage outputs
  always_comb begin
    state_d        = state_q;
    link_valid_d   = link_valid_q;
    link_addr_d    = link_addr_q;
    ldata_d        = ldata_q;
    pend_flush_d   = pend_flush_q;
    dmemREN        = 1'b0;
    dmemWEN        = 1'b0;
    mem_stall      = 1'b0;
    memwb_writeEN  = 1'b0;
    memwb_flush    = 1'b0;
    aluOutport_out = aluOutport_in;
    dmemload_out   = dmemload;

    case (state_q)
      IDLE: begin
        if (memop && !flush_in) begin
          state_d   = BUSY;
          mem_stall = 1'b1;
        end else begin
          memwb_writeEN = exmem_valid && !flush_in;
          memwb_flush   = flush_in || !exmem_valid;
          if (sc_fail) begin
            aluOutport_out = '0;
            if (exmem_valid && !flush_in) link_valid_d = 1'b0;
          end
        end
      end
      BUSY: begin
        dmemREN   = dREN_in;
        dmemWEN   = dWEN_in;
        mem_stall = 1'b1;
        if (flush_in) pend_flush_d = 1'b1;
        if (dhit) begin
          ldata_d = dmemload;
          state_d = DONE;
        end
      end
      DONE: begin
        memwb_writeEN = !pend_flush_q;
        memwb_flush   = pend_flush_q;
        dmemload_out  = ldata_q;
        pend_flush_d  = 1'b0;
        state_d       = IDLE;
        if (SC_in) begin
          aluOutport_out = 32'd1;
          link_valid_d   = 1'b0;
        end else if (dWEN_in && (aluOutport_in == link_addr_q)) begin
          link_valid_d = 1'b0;
        end
        if (LL_in) begin
          link_valid_d = 1'b1;
          link_addr_d  = aluOutport_in;
        end
      end
      default: state_d = IDLE;
    endcase

    // Snoop invalidate is applied last so it beats a same-cycle LL set
    if (ccinv && (ccsnoopaddr == link_addr_d)) link_valid_d = 1'b0;

    // Reset overrides the handshake immediately, even mid-access
    if (!nRST) begin
      dmemREN       = 1'b0;
      dmemWEN       = 1'b0;
      mem_stall     = 1'b0;
      memwb_writeEN = 1'b0;
      memwb_flush   = 1'b1;
    end
  end

  // State and link registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      ldata_q      <= '0;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      ldata_q      <= ldata_d;
      pend_flush_q <= pend_flush_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model checks every
// cycle, and per-scenario literal expectations pin the model.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        exmem_valid;
  logic [31:0] aluOutport_in, storedata_in, pcplus4_in;
  logic [4:0]  rt_in, rd_in;
  logic        dREN_in, dWEN_in, LL_in, SC_in, flush_in;
  logic [5:0]  ctrl_in;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, ccinv;
  logic [31:0] dmemload, ccsnoopaddr;
  logic [31:0] aluOutport_out, dmemload_out, pcplus4_out;
  logic [4:0]  rt_out, rd_out;
  logic [5:0]  ctrl_out;
  logic        memwb_writeEN, memwb_flush, mem_stall;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .nRST(nRST),
    .exmem_valid(exmem_valid), .aluOutport_in(aluOutport_in),
    .storedata_in(storedata_in), .pcplus4_in(pcplus4_in),
    .rt_in(rt_in), .rd_in(rd_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .LL_in(LL_in), .SC_in(SC_in), .ctrl_in(ctrl_in), .flush_in(flush_in),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .aluOutport_out(aluOutport_out), .dmemload_out(dmemload_out),
    .pcplus4_out(pcplus4_out), .rt_out(rt_out), .rd_out(rd_out),
    .ctrl_out(ctrl_out), .memwb_writeEN(memwb_writeEN),
    .memwb_flush(memwb_flush), .mem_stall(mem_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an access is either waiting for the cache, has a result
  // to present, or is not in flight; the reservation is a (valid, addr) pair.
  bit          m_wait = 0, m_res = 0, m_kill = 0, r_valid = 0;
  logic [31:0] m_data = '0, r_addr = '0;

  always @(negedge CLK) begin : model
    logic        e_ren, e_wen, e_stall, e_we, e_fl;
    logic [31:0] e_alu, e_ld;
    bit          full, sc_ok;
    full = 1; e_ren = 0; e_wen = 0; e_stall = 0; e_we = 0; e_fl = 0;
    e_alu = aluOutport_in; e_ld = dmemload;
    if (!nRST) begin
      full = 0; e_fl = 1;
      m_wait = 0; m_res = 0; m_kill = 0; m_data = '0; r_valid = 0; r_addr = '0;
    end else if (m_wait) begin
      e_ren = dREN_in; e_wen = dWEN_in; e_stall = 1;
      if (flush_in) m_kill = 1;
      if (dhit) begin m_wait = 0; m_res = 1; m_data = dmemload; end
    end else if (m_res) begin
      e_we = !m_kill; e_fl = m_kill; e_ld = m_data;
      if (SC_in) begin e_alu = 32'd1; r_valid = 0; end
      else if (dWEN_in && aluOutport_in == r_addr) r_valid = 0;
      if (LL_in) begin r_valid = 1; r_addr = aluOutport_in; end
      m_kill = 0; m_res = 0;
    end else begin
      sc_ok = !SC_in || (r_valid && r_addr == aluOutport_in);
      if (exmem_valid && (dREN_in || dWEN_in) && sc_ok && !flush_in) begin
        e_stall = 1; m_wait = 1;
      end else begin
        e_we = exmem_valid && !flush_in;
        e_fl = flush_in || !exmem_valid;
        if (!sc_ok) begin
          e_alu = '0;
          if (exmem_valid && !flush_in) r_valid = 0;
        end
      end
    end
    if (nRST && ccinv && ccsnoopaddr == r_addr) r_valid = 0;

    chk("m_stall", mem_stall, e_stall);
    chk("m_ren", dmemREN, e_ren);
    chk("m_wen", dmemWEN, e_wen);
    chk("m_wb_we", memwb_writeEN, e_we);
    chk("m_wb_flush", memwb_flush, e_fl);
    if (full) begin
      chk("m_alu", aluOutport_out, e_alu);
      chk("m_ldata", dmemload_out, e_ld);
      chk("m_pc4", pcplus4_out, pcplus4_in);
      chk("m_ctrl", ctrl_out, ctrl_in);
      chk("m_rd", rd_out, rd_in);
      chk("m_rt", rt_out, rt_in);
    end
    if (e_ren || e_wen) begin
      chk("m_addr", dmemaddr, aluOutport_in);
      chk("m_store", dmemstore, storedata_in);
    end
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] sd,
                       input bit ren, input bit wen, input bit ll, input bit sc);
    exmem_valid = v; aluOutport_in = a; storedata_in = sd;
    dREN_in = ren; dWEN_in = wen; LL_in = ll; SC_in = sc;
    pcplus4_in = a + 32'd4;
    rt_in = a[4:0];
    rd_in = a[6:2];
    ctrl_in = {ren, 1'b0, !ren, !wen, 1'b0, sc};
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // LL at address a; optionally snoop the same address during its result cycle
  task automatic run_ll(input logic [31:0] a, input bit snoop_same);
    drive(1, a, '0, 1, 0, 1, 0);
    mid(); chk("ll_idle_stall", mem_stall, 1); tick();
    dhit = 1; dmemload = 32'h77;
    mid(); chk("ll_busy_ren", dmemREN, 1); tick();
    dhit = 0; dmemload = '0;
    if (snoop_same) begin ccinv = 1; ccsnoopaddr = a; end
    mid(); chk("ll_done_we", memwb_writeEN, 1); chk("ll_done_data", dmemload_out, 32'h77); tick();
    ccinv = 0; drive(0, '0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    nRST = 0; flush_in = 0; dhit = 0; dmemload = '0; ccinv = 0; ccsnoopaddr = '0;
    drive(0, '0, '0, 0, 0, 0, 0);
    // reset forcing
    mid(); chk("rst_stall", mem_stall, 0); chk("rst_flush", memwb_flush, 1);
    chk("rst_we", memwb_writeEN, 0); tick();
    mid(); tick();
    nRST = 1;

    // SC straight out of reset has no reservation
    drive(1, 32'h200, 32'h5, 0, 1, 0, 1);
    mid(); chk("sc_rst_alu", aluOutport_out, 0); chk("sc_rst_wen", dmemWEN, 0);
    chk("sc_rst_stall", mem_stall, 0); tick();

    // load with dhit in second BUSY cycle
    drive(1, 32'h100, '0, 1, 0, 0, 0);
    mid(); chk("ld_c1_stall", mem_stall, 1); chk("ld_c1_we", memwb_writeEN, 0);
    chk("ld_c1_ren", dmemREN, 0); tick();
    mid(); chk("ld_c2_ren", dmemREN, 1); chk("ld_c2_addr", dmemaddr, 32'h100);
    chk("ld_c2_stall", mem_stall, 1); tick();
    dhit = 1; dmemload = 32'hDEADBEEF;
    mid(); chk("ld_c3_stall", mem_stall, 1); tick();
    dhit = 0; dmemload = 32'h12345678;
    mid(); chk("ld_c4_stall", mem_stall, 0); chk("ld_c4_we", memwb_writeEN, 1);
    chk("ld_c4_data", dmemload_out, 32'hDEADBEEF); chk("ld_c4_ren", dmemREN, 0); tick();

    // non-memop add, with a stray dhit that must be ignored
    drive(1, 32'h55, '0, 0, 0, 0, 0); dhit = 1;
    mid(); chk("add_we", memwb_writeEN, 1); chk("add_stall", mem_stall, 0);
    chk("add_alu", aluOutport_out, 32'h55); chk("add_rd", rd_out, 32'h15);
    chk("add_pc4", pcplus4_out, 32'h59); tick();
    dhit = 0; drive(0, '0, '0, 0, 0, 0, 0);
    mid(); chk("bubble_stall", mem_stall, 0); chk("bubble_flush", memwb_flush, 1); tick();

    // LL/SC pass; a snoop differing only in bit 31 must not break the link
    run_ll(32'h200, 0);
    ccinv = 1; ccsnoopaddr = 32'h8000_0200;
    mid(); tick();
    ccinv = 0;
    drive(1, 32'h200, 32'h99, 0, 1, 0, 1);
    mid(); chk("sc_c1_stall", mem_stall, 1); tick();
    dhit = 1;
    mid(); chk("sc_c2_wen", dmemWEN, 1); chk("sc_c2_store", dmemstore, 32'h99);
    chk("sc_c2_addr", dmemaddr, 32'h200); tick();
    dhit = 0;
    mid(); chk("sc_done_alu", aluOutport_out, 1); chk("sc_done_we", memwb_writeEN, 1);
    chk("sc_done_wen", dmemWEN, 0); tick();
    mid(); chk("sc_again_alu", aluOutport_out, 0); chk("sc_again_stall", mem_stall, 0); tick();

    // LL, snoop invalidate, SC fails in one cycle
    run_ll(32'h200, 0);
    ccinv = 1; ccsnoopaddr = 32'h200;
    mid(); tick();
    ccinv = 0;
    drive(1, 32'h200, 32'h99, 0, 1, 0, 1);
    mid(); chk("scf_alu", aluOutport_out, 0); chk("scf_wen", dmemWEN, 0);
    chk("scf_stall", mem_stall, 0); chk("scf_we", memwb_writeEN, 1); tick();
    drive(0, '0, '0, 0, 0, 0, 0);
    mid(); chk("scf_next_wen", dmemWEN, 0); tick();

    // snoop in the same cycle as the LL set wins
    run_ll(32'h300, 1);
    drive(1, 32'h300, 32'h1, 0, 1, 0, 1);
    mid(); chk("race_alu", aluOutport_out, 0); chk("race_stall", mem_stall, 0); tick();

    // flush during a store: access completes, result is flushed
    drive(1, 32'h400, 32'hCAFE, 0, 1, 0, 0);
    mid(); chk("fs_c1_stall", mem_stall, 1); tick();
    flush_in = 1;
    mid(); chk("fs_c2_wen", dmemWEN, 1); tick();
    flush_in = 0;
    mid(); chk("fs_c3_wen", dmemWEN, 1); chk("fs_c3_store", dmemstore, 32'hCAFE); tick();
    dhit = 1;
    mid(); chk("fs_c4_wen", dmemWEN, 1); tick();
    dhit = 0;
    mid(); chk("fs_done_flush", memwb_flush, 1); chk("fs_done_we", memwb_writeEN, 0);
    chk("fs_done_wen", dmemWEN, 0); chk("fs_done_stall", mem_stall, 0); tick();
    drive(0, '0, '0, 0, 0, 0, 0);
    mid(); tick();

    // reset during a load's BUSY cycle
    drive(1, 32'h500, '0, 1, 0, 0, 0);
    mid(); tick();
    nRST = 0;
    mid(); chk("rb_ren", dmemREN, 0); chk("rb_stall", mem_stall, 0);
    chk("rb_flush", memwb_flush, 1); tick();
    nRST = 1; drive(0, '0, '0, 0, 0, 0, 0);
    mid(); chk("rb_next_ren", dmemREN, 0); chk("rb_next_stall", mem_stall, 0); tick();
    drive(1, 32'h10, '0, 0, 0, 0, 0);
    mid(); chk("rb_add_we", memwb_writeEN, 1); chk("rb_add_stall", mem_stall, 0); tick();
    drive(0, '0, '0, 0, 0, 0, 0);
    mid(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
